// File: rtl/passcode_pkg.sv
// Shared definitions for the keypad passcode lock: state encodings, key codes
// and a small key-classification helper. The display block imports this too.
package passcode_pkg;

    // FSM state encodings, also shown on the display
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;
    localparam logic [2:0] S_SET     = 3'd6;

    // Non-digit key codes from the keypad decoder
    localparam logic [3:0] KEY_CHANGE = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hE;
    localparam logic [3:0] KEY_ENTER  = 4'hF;

    // Keys 0-9 are digits; B, C and D are unused and never act as digits
    function automatic logic is_digit(input logic [3:0] key);
        return (key < 4'd10);
    endfunction

endpackage

// File: rtl/passcode_if.sv
// Key strobe / status bundle between the keypad front end, the passcode
// controller and the display block.
interface passcode_if;
    logic       tick;
    logic       key_vld;
    logic [3:0] key_val;
    logic       unlocked;
    logic       locked_out;
    logic       err;
    logic [2:0] state;
    logic [3:0] entry_cnt;
    logic [3:0] fail_cnt;

    // Keypad side: produces strobes and timebase, observes status
    modport master (
        output tick, key_vld, key_val,
        input  unlocked, locked_out, err, state, entry_cnt, fail_cnt
    );

    // Controller side
    modport slave (
        input  tick, key_vld, key_val,
        output unlocked, locked_out, err, state, entry_cnt, fail_cnt
    );
endinterface

// File: rtl/passcode_tick_timer.sv
// Loadable down-counter advanced by the timebase tick. A load always wins over
// a tick in the same cycle, and the count holds at zero once it gets there.
module tick_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Reload on request, otherwise count down one per tick until empty
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/passcode_ctrl.sv
// Keypad passcode lock sequencer: digit buffer, stored code, failure counter
// and one shared timer for the OPEN, LOCKOUT and inactivity intervals.
module passcode_ctrl
    import passcode_pkg::*;
#(
    parameter int                      CODE_LEN     = 4,
    parameter logic [CODE_LEN*4-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                      MAX_TRIES    = 3,
    parameter int                      OPEN_TICKS   = 1000,
    parameter int                      LOCK_TICKS   = 2000,
    parameter int                      INACT_TICKS  = 1000
) (
    input  logic       clk,
    input  logic       clr_n,
    passcode_if.slave  bus
);

    localparam int BUF_W  = CODE_LEN * 4;
    localparam int MAX_T1 = (OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS;
    localparam int MAX_T  = (MAX_T1 > INACT_TICKS) ? MAX_T1 : INACT_TICKS;
    localparam int TMR_W  = $clog2(MAX_T + 1);

    localparam logic [TMR_W-1:0] T_OPEN  = TMR_W'(OPEN_TICKS);
    localparam logic [TMR_W-1:0] T_LOCK  = TMR_W'(LOCK_TICKS);
    localparam logic [TMR_W-1:0] T_INACT = TMR_W'(INACT_TICKS);
    localparam logic [3:0]       FULL    = 4'(CODE_LEN);
    localparam logic [3:0]       TRIES   = 4'(MAX_TRIES);

    logic [2:0]       state_reg, state_next;
    logic [BUF_W-1:0] buf_reg, buf_next;
    logic [BUF_W-1:0] code_reg, code_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       fail_reg, fail_next;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;

    logic             key_digit;
    logic             key_clear;
    logic             key_enter;
    logic             key_change;
    logic [3:0]       fail_inc;

    assign key_digit  = bus.key_vld && is_digit(bus.key_val);
    assign key_clear  = bus.key_vld && (bus.key_val == KEY_CLEAR);
    assign key_enter  = bus.key_vld && (bus.key_val == KEY_ENTER);
    assign key_change = bus.key_vld && (bus.key_val == KEY_CHANGE);
    assign fail_inc   = fail_reg + 4'd1;

    tick_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .clr_n    (clr_n),
        .tick     (bus.tick),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state logic; a key in ENTRY/SET reloads the timer, so it always
    // outranks a tick or expiry seen in the same cycle
    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        cnt_next   = cnt_reg;
        code_next  = code_reg;
        fail_next  = fail_reg;
        tmr_load   = 1'b0;
        tmr_val    = T_INACT;

        case (state_reg)
            S_IDLE: begin
                if (key_digit) begin
                    state_next = S_ENTRY;
                    buf_next   = BUF_W'(bus.key_val);
                    cnt_next   = 4'd1;
                    tmr_load   = 1'b1;
                    tmr_val    = T_INACT;
                end
            end

            S_ENTRY, S_SET: begin
                if (bus.key_vld) begin
                    tmr_load = 1'b1;
                    tmr_val  = T_INACT;
                    if (key_digit) begin
                        if (cnt_reg < FULL) begin
                            buf_next = (buf_reg << 4) | BUF_W'(bus.key_val);
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end else if (key_clear) begin
                        buf_next = '0;
                        cnt_next = 4'd0;
                    end else if (key_enter) begin
                        if (state_reg == S_ENTRY) begin
                            state_next = S_CHECK;
                        end else begin
                            // Short entries back out to OPEN leaving the code alone
                            if (cnt_reg == FULL) begin
                                code_next = buf_reg;
                            end
                            state_next = S_OPEN;
                            buf_next   = '0;
                            cnt_next   = 4'd0;
                            tmr_val    = T_OPEN;
                        end
                    end
                end else if (tmr_zero) begin
                    state_next = S_IDLE;
                    buf_next   = '0;
                    cnt_next   = 4'd0;
                end
            end

            S_CHECK: begin
                if ((cnt_reg == FULL) && (buf_reg == code_reg)) begin
                    state_next = S_OPEN;
                    fail_next  = 4'd0;
                    tmr_load   = 1'b1;
                    tmr_val    = T_OPEN;
                end else begin
                    state_next = S_FAIL;
                end
                // The entered code is not kept around once it has been judged
                buf_next = '0;
                cnt_next = 4'd0;
            end

            S_FAIL: begin
                fail_next = fail_inc;
                buf_next  = '0;
                cnt_next  = 4'd0;
                if (fail_inc == TRIES) begin
                    state_next = S_LOCKOUT;
                    tmr_load   = 1'b1;
                    tmr_val    = T_LOCK;
                end else begin
                    state_next = S_IDLE;
                end
            end

            S_LOCKOUT: begin
                if (tmr_zero) begin
                    state_next = S_IDLE;
                    fail_next  = 4'd0;
                end
            end

            S_OPEN: begin
                if (key_change) begin
                    state_next = S_SET;
                    buf_next   = '0;
                    cnt_next   = 4'd0;
                    tmr_load   = 1'b1;
                    tmr_val    = T_INACT;
                end else if (key_enter || tmr_zero) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
                buf_next   = '0;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State, buffer, code and failure counter registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= S_IDLE;
            buf_reg   <= '0;
            code_reg  <= DEFAULT_CODE;
            cnt_reg   <= 4'd0;
            fail_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            code_reg  <= code_next;
            cnt_reg   <= cnt_next;
            fail_reg  <= fail_next;
        end
    end

    // Status is decoded straight from registers so it never glitches
    assign bus.state      = state_reg;
    assign bus.unlocked   = (state_reg == S_OPEN) || (state_reg == S_SET);
    assign bus.locked_out = (state_reg == S_LOCKOUT);
    assign bus.err        = (state_reg == S_FAIL);
    assign bus.entry_cnt  = cnt_reg;
    assign bus.fail_cnt   = fail_reg;

endmodule
